// File: rtl/cbus_arbiter.sv
// cbus_arbiter: shares one memory bus port between the fetch (ibus) and
// memory (dbus) stages. Only one transaction is outstanding at a time.
// dbus wins ties because a dbus stall freezes the pipeline. A streak
// limiter forces an ibus grant after MAX_D_STREAK back-to-back dbus wins
// while ibus is waiting.
//
// state  | meaning
// IDLE   | no transaction outstanding, arbitrate this cycle
// BUSY_I | ibus request latched and presented on the shared bus
// BUSY_D | dbus request latched and presented on the shared bus
module cbus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [63:0]      i_addr,
    output logic             i_addr_ok,
    output logic             i_data_ok,
    output logic [31:0]      i_data,
    input  logic             d_valid,
    input  logic [63:0]      d_addr,
    input  logic [2:0]       d_size,
    input  logic [7:0]       d_strobe,
    input  logic [63:0]      d_wdata,
    output logic             d_addr_ok,
    output logic             d_data_ok,
    output logic [63:0]      d_data,
    output logic             m_valid,
    output logic [63:0]      m_addr,
    output logic [2:0]       m_size,
    output logic [7:0]       m_strobe,
    output logic [63:0]      m_wdata,
    input  logic             m_data_ok,
    input  logic [63:0]      m_data,
    output logic [CNT_W-1:0] i_grants,
    output logic [CNT_W-1:0] d_grants
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t           r_state;
    logic             r_m_valid;
    logic [63:0]      r_addr;
    logic [2:0]       r_size;
    logic [7:0]       r_strobe;
    logic [63:0]      r_wdata;
    logic [3:0]       r_streak;
    logic [CNT_W-1:0] r_i_grants;
    logic [CNT_W-1:0] r_d_grants;

    logic w_grant_d;
    logic w_grant_i;
    logic w_done_i;
    logic w_done_d;

    // dbus wins unless ibus is waiting and the dbus streak has hit its limit
    assign w_grant_d = d_valid & (~i_valid | (r_streak != STREAK_MAX));
    assign w_grant_i = i_valid & ~w_grant_d;

    // A completion is the memory response while a transaction is owned
    assign w_done_i = (r_state == BUSY_I) & m_data_ok;
    assign w_done_d = (r_state == BUSY_D) & m_data_ok;

    // Arbitration FSM; the request is latched on grant so the shared bus
    // stays stable even if the requester changes its fields mid-flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
            r_addr    <= 64'd0;
            r_size    <= 3'd0;
            r_strobe  <= 8'd0;
            r_wdata   <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state   <= BUSY_D;
                        r_m_valid <= 1'b1;
                        r_addr    <= d_addr;
                        r_size    <= d_size;
                        r_strobe  <= d_strobe;
                        r_wdata   <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state   <= BUSY_I;
                        r_m_valid <= 1'b1;
                        r_addr    <= i_addr;
                        r_size    <= 3'd2;
                        r_strobe  <= 8'd0;
                        r_wdata   <= 64'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (m_data_ok) begin
                        r_state   <= IDLE;
                        r_m_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    // Streak of dbus wins while ibus waits; any ibus completion or a dbus
    // completion with no ibus request pending restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= 4'd0;
        end else if (w_done_i) begin
            r_streak <= 4'd0;
        end else if (w_done_d) begin
            if (!i_valid)
                r_streak <= 4'd0;
            else if (r_streak != STREAK_MAX)
                r_streak <= r_streak + 4'd1;
        end
    end

    // Completed-transaction counters, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i_grants <= '0;
            r_d_grants <= '0;
        end else begin
            if (w_done_i)
                r_i_grants <= r_i_grants + 1'b1;
            if (w_done_d)
                r_d_grants <= r_d_grants + 1'b1;
        end
    end

    assign m_valid   = r_m_valid;
    assign m_addr    = r_addr;
    assign m_size    = r_size;
    assign m_strobe  = r_strobe;
    assign m_wdata   = r_wdata;

    // Responses are passed through combinationally in the completion cycle
    assign i_addr_ok = w_done_i;
    assign i_data_ok = w_done_i;
    assign i_data    = w_done_i ? (r_addr[2] ? m_data[63:32] : m_data[31:0]) : 32'd0;
    assign d_addr_ok = w_done_d;
    assign d_data_ok = w_done_d;
    assign d_data    = w_done_d ? m_data : 64'd0;

    assign i_grants  = r_i_grants;
    assign d_grants  = r_d_grants;

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- Shares one memory bus port between the fetch stage (ibus) and the memory stage (dbus). One transaction is outstanding at a time.
- dbus has priority by default, because a dbus stall freezes the pipeline. A streak limiter prevents ibus starvation.
- Sits at the core boundary, between the core's ibus/dbus request/response pair and the single shared bus toward memory.

Parameters:
- MAX_D_STREAK, 4: consecutive dbus grants allowed while ibus is pending before ibus is forced a grant; legal range 1..15.
- CNT_W, 32: width of the per-requester grant counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- i_valid  in  1  ibus request valid
- i_addr  in  64  ibus address
- i_addr_ok  out  1  ibus request accepted
- i_data_ok  out  1  ibus response valid
- i_data  out  32  ibus instruction
- d_valid  in  1  dbus request valid
- d_addr  in  64  dbus address
- d_size  in  3  dbus access size (log2 bytes)
- d_strobe  in  8  dbus byte write strobe; 0 = read
- d_wdata  in  64  dbus write data
- d_addr_ok  out  1  dbus request accepted
- d_data_ok  out  1  dbus response valid
- d_data  out  64  dbus read data
- m_valid  out  1  shared bus request valid
- m_addr  out  64  shared bus address
- m_size  out  3  shared bus size
- m_strobe  out  8  shared bus strobe
- m_wdata  out  64  shared bus write data
- m_data_ok  in  1  shared bus response valid
- m_data  in  64  shared bus read data
- i_grants  out  CNT_W  completed ibus transactions
- d_grants  out  CNT_W  completed dbus transactions

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. Reset value is IDLE.
- Reset values: all outputs 0, streak counter 0, request latches 0.
- Arbitration in IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant dbus unless streak == MAX_D_STREAK; in that case grant ibus.
  - On grant, latch the winner's request fields and go to BUSY_x on the next edge.
  - No valid requester: stay in IDLE.
- ibus latch values: size = 3'd2, strobe = 0, wdata = 0.
- BUSY_x outputs:
  - m_valid = 1.
  - m_addr, m_size, m_strobe and m_wdata are driven only from the latched copy, so they stay stable until m_data_ok.
- m_data_ok handling in BUSY_x (same cycle, combinational):
  - Assert the owner's addr_ok and data_ok; the non-owner's are 0.
  - i_data = m_data[31:0] if i_addr[2] == 0, else m_data[63:32]; use the latched address bit.
  - d_data = m_data.
  - Next state is IDLE, so there is at least one IDLE cycle between transactions.
  - The owner's grant counter increments, wrapping modulo 2^CNT_W.
- Minimum latency: request valid in cycle N → m_valid in cycle N+1 → earliest data_ok in cycle N+1, if memory responds in the same cycle.
- Streak counter updates at each dbus completion:
  - i_valid high: increment, saturating at MAX_D_STREAK.
  - i_valid low: clear to 0.
  - Any ibus completion also clears it to 0.
- Requesters must hold valid and fields until data_ok. If a requester drops valid mid-transaction, the latched transaction still completes and its data_ok is still delivered.
- m_data_ok in IDLE: ignored, no outputs asserted.
- Asynchronous reset mid-transaction: immediate return to IDLE with all outputs 0. The pending response is dropped; memory is reset by the same signal.
- Outside BUSY_x with m_data_ok, addr_ok, data_ok and data outputs are 0.

Test Plan:
- ibus read: i_valid = 1, i_addr = 0x8000_0004; memory returns m_data = 0x1111_2222_3333_4444 after 2 cycles → m_valid held 2 cycles with m_addr = 0x8000_0004, m_size = 2; i_data_ok = 1 with i_data = 0x1111_2222; i_grants = 1.
- Simultaneous request: i_valid = d_valid = 1 in IDLE, d_strobe = 0xFF, d_wdata = 0xDEAD → dbus granted first with m_strobe = 0xFF, m_wdata = 0xDEAD; ibus granted after one IDLE cycle.
- Starvation: i_valid held high, dbus requesting continuously, MAX_D_STREAK = 4 → four dbus completions, then the ibus grant, then the streak resets to 0.
- Stability: during BUSY_D, change d_addr and d_valid → m_addr unchanged; d_data_ok still pulses on m_data_ok.
- Spurious response: m_data_ok = 1 in IDLE → no data_ok outputs, counters unchanged.
- Reset: reset low during BUSY_I → same-cycle m_valid = 0 and all outputs 0; after release, state is IDLE and counters are 0.
